alu_round_ctrl: RTL and testbench
=================================

// Module: alu_round_ctrl
// PURPOSE
//  Multi-round byte cipher sequencer that owns the 8-bit ALU (ADD/SUB/XOR/PASS, enable-gated, combinational).
//  Accepts one byte + key per start, runs R rounds through the ALU, returns the result with a done pulse.
//  Encrypt round: x = (x ^ k) + k.  Decrypt round: x = (x - k) ^ k.  Sits between host regs and the ALU.
// PARAMETERS
//  ROUND_W  4  width of rounds input; 0..2^ROUND_W-1 rounds per job
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        job request; sampled only in IDLE
//  decrypt     in   1        0 = encrypt, 1 = decrypt; captured with start
//  rounds      in   ROUND_W  round count R; captured with start
//  data_in     in   8        plaintext/ciphertext byte; captured with start
//  key         in   8        round-0 key; captured with start
//  busy        out  1        high from cycle after accepted start until done cycle (exclusive)
//  done        out  1        one-cycle pulse when data_out updates
//  data_out    out  8        registered result; holds until next job completes
//  alu_enable  out  1        ALU enable; 0 in IDLE/DONE
//  alu_opcode  out  4        ALU opcode (package constants)
//  alu_a       out  8        ALU operand a
//  alu_b       out  8        ALU operand b
//  alu_result  in   8        ALU result (combinational from a/b/opcode)
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; busy=0, done=0, data_out=0, alu_enable=0, opcode=0, a=b=0.
//  States: IDLE -> LOAD -> {PH_A -> PH_B} x R -> DONE -> IDLE.
//   IDLE: start=1 at edge T captures decrypt/rounds/data_in/key, go LOAD. start=0: stay.
//   LOAD (T+1): opcode=PASS, a=0, b=data_reg; x<=alu_result; R=0 -> DONE else PH_A.
//   PH_A: a=x, b=k; opcode XOR (enc) / SUB (dec); x<=alu_result.
//   PH_B: a=x, b=k; opcode ADD (enc) / XOR (dec); x<=alu_result; round_cnt++;
//         round_cnt==R -> DONE else PH_A.
//   DONE: data_out<=x, done=1 for exactly this cycle, busy=0; next IDLE.
//  Latency: start at T -> done at T+2+2R (R=0: T+2). Back-to-back: next start sampled in IDLE, earliest T+3+2R.
//  ALU drive outputs are combinational from state regs; x, k, round_cnt registered.
//  Arithmetic: 8-bit modulo 2^8, carry/borrow discarded (ALU width).
//  start while busy/DONE: ignored, not queued. Inputs changing mid-job: no effect (captured copies used).
//  Reset mid-job: abort, return IDLE next cycle, no done pulse, data_out cleared to 0.
//  Max R = 2^ROUND_W-1; round_cnt is ROUND_W bits, never wraps.
// CONFIGURATION
//  KEY_ROTATE_EN defined: per-round key schedule. Enc: k starts = key, rotl(k,1) after each PH_B.
//   Dec: k starts = rotl(key, (R-1) mod 8) (R=0: key), rotr(k,1) after each PH_B. Latency unchanged.
//  KEY_ROTATE_EN undefined: k = captured key for all rounds; rotate logic absent.
// STRUCTURE
//  Shared package crypto_pkg: OP_ADD=4'b0001, OP_SUB=4'b0010, OP_XOR=4'b0011, OP_PASS=4'b0100;
//   state enum (IDLE, LOAD, PH_A, PH_B, DONE); byte width constant 8.
//  One sub-module: key_sched (load/rotate key register, only under KEY_ROTATE_EN). FSM + datapath in top.
//  ALU instantiated by parent, not inside this block.
// TESTING (bench instantiates real ALU beside controller)
//  Enc data 0x3C key 0x5A R=1 -> done at T+4, data_out=0xC0; ALU ops seen PASS, XOR, ADD.
//  Dec data 0xC0 key 0x5A R=1 -> data_out=0x3C; ops PASS, SUB, XOR.
//  Enc 0x7F key 0xC0 R=1 -> 0x7F (ADD wrap); enc 0x3C key 0x5A R=2 -> 0xF4 (no rotate) / 0x28 (KEY_ROTATE_EN);
//   dec 0x28 key 0x5A R=2 with KEY_ROTATE_EN -> 0x3C.
//  R=0, data 0xA5 -> done at T+2, data_out=0xA5; start pulsed while busy -> ignored, single done.
//  rst asserted mid PH_A -> next cycle IDLE, busy=0, data_out=0, no done; new start then completes normally.
//  Reset values of all outputs checked; done never wider than 1 cycle; alu_enable=0 whenever idle.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared constants for the byte-cipher round controller: ALU opcodes, FSM states, rotate helpers.
`default_nettype none

package crypto_pkg;

  localparam int BYTE_W = 8;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PH_A = 3'd2,
    PH_B = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] x, input logic [2:0] n);
    logic [2*BYTE_W-1:0] d;
    d = {x, x} << n;
    return d[2*BYTE_W-1:BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] rotr8(input logic [BYTE_W-1:0] x, input logic [2:0] n);
    logic [2*BYTE_W-1:0] d;
    d = {x, x} >> n;
    return d[BYTE_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_round_ctrl_key_sched.sv
// key_sched: per-round key register; loads the round-0 key on job accept and rotates after each PH_B.
// Only instantiated when KEY_ROTATE_EN is defined.
`default_nettype none

module key_sched
  import crypto_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               decrypt,
  input  logic [ROUND_W-1:0] rounds,
  input  logic [BYTE_W-1:0]  key,
  output logic [BYTE_W-1:0]  k
);

  logic [ROUND_W-1:0] rounds_m1;
  logic [2:0]         dec_shift;
  logic [BYTE_W-1:0]  load_val;
  logic               dec_q;

  assign rounds_m1 = rounds - ROUND_W'(1);
  assign dec_shift = 3'(rounds_m1);

  // Decrypt walks the schedule backwards, so it starts from the last round's key.
  always_comb begin
    load_val = key;
    if (decrypt && (rounds != '0)) begin
      load_val = rotl8(key, dec_shift);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      dec_q <= 1'b0;
    end else if (load) begin
      k     <= load_val;
      dec_q <= decrypt;
    end else if (step) begin
      k <= dec_q ? rotr8(k, 3'd1) : rotl8(k, 3'd1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_round_ctrl.sv
// alu_round_ctrl: multi-round byte cipher sequencer driving an external 8-bit ALU.
// Optional per-round key rotation is enabled by defining KEY_ROTATE_EN.
`default_nettype none

module alu_round_ctrl
  import crypto_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic [ROUND_W-1:0] rounds,
  input  logic [BYTE_W-1:0]  data_in,
  input  logic [BYTE_W-1:0]  key,
  output logic               busy,
  output logic               done,
  output logic [BYTE_W-1:0]  data_out,
  output logic               alu_enable,
  output logic [3:0]         alu_opcode,
  output logic [BYTE_W-1:0]  alu_a,
  output logic [BYTE_W-1:0]  alu_b,
  input  logic [BYTE_W-1:0]  alu_result
);

  state_t             state;
  state_t             state_next;
  logic               dec_q;
  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] round_cnt;
  logic [ROUND_W-1:0] cnt_inc;
  logic [BYTE_W-1:0]  data_q;
  logic [BYTE_W-1:0]  x_q;
  logic [BYTE_W-1:0]  k;
  logic               accept;
  logic               last_round;

  assign accept     = (state == IDLE) && start;
  assign cnt_inc    = round_cnt + ROUND_W'(1);
  assign last_round = (cnt_inc == rounds_q);

`ifdef KEY_ROTATE_EN
  key_sched #(
    .ROUND_W (ROUND_W)
  ) u_key_sched (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (state == PH_B),
    .decrypt (decrypt),
    .rounds  (rounds),
    .key     (key),
    .k       (k)
  );
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
    end else if (accept) begin
      k <= key;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (rounds_q == '0) ? DONE : PH_A;
      PH_A:    state_next = PH_B;
      PH_B:    state_next = last_round ? DONE : PH_A;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_enable = 1'b0;
    alu_opcode = OP_NONE;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      LOAD: begin
        alu_enable = 1'b1;
        alu_opcode = OP_PASS;
        alu_b      = data_q;
      end
      PH_A: begin
        alu_enable = 1'b1;
        alu_opcode = dec_q ? OP_SUB : OP_XOR;
        alu_a      = x_q;
        alu_b      = k;
      end
      PH_B: begin
        alu_enable = 1'b1;
        alu_opcode = dec_q ? OP_XOR : OP_ADD;
        alu_a      = x_q;
        alu_b      = k;
      end
      default: ;
    endcase
  end

  assign busy = (state == LOAD) || (state == PH_A) || (state == PH_B);
  assign done = (state == DONE);

  // data_out is loaded on the edge entering DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q     <= 1'b0;
      rounds_q  <= '0;
      data_q    <= '0;
      x_q       <= '0;
      round_cnt <= '0;
      data_out  <= '0;
    end else begin
      if (accept) begin
        dec_q    <= decrypt;
        rounds_q <= rounds;
        data_q   <= data_in;
      end
      case (state)
        LOAD: begin
          x_q       <= alu_result;
          round_cnt <= '0;
          if (rounds_q == '0) data_out <= alu_result;
        end
        PH_A: x_q <= alu_result;
        PH_B: begin
          x_q       <= alu_result;
          round_cnt <= cnt_inc;
          if (last_round) data_out <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_round_ctrl.sv
// Directed bench for alu_round_ctrl with a behavioural 8-bit ALU beside the controller.
`default_nettype none

module tb_alu_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic [3:0] rounds = 4'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] key = 8'h00;
  logic       busy, done, alu_enable;
  logic [7:0] data_out, alu_a, alu_b, alu_result;
  logic [3:0] alu_opcode;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic prev_done = 1'b0;
  logic [3:0] ops[$];

  always #5 clk = ~clk;

  alu_round_ctrl #(.ROUND_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .decrypt    (decrypt),
    .rounds     (rounds),
    .data_in    (data_in),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always_comb begin
    alu_result = 8'h00;
    if (alu_enable) begin
      case (alu_opcode)
        4'b0001: alu_result = alu_a + alu_b;
        4'b0010: alu_result = alu_a - alu_b;
        4'b0011: alu_result = alu_a ^ alu_b;
        4'b0100: alu_result = alu_b;
        default: alu_result = 8'h00;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (alu_enable) ops.push_back(alu_opcode);
    if (done) n_done++;
    if (!busy) chk("en_idle", {31'd0, alu_enable}, 32'd0);
    chk("done_width", {31'd0, done & prev_done}, 32'd0);
    prev_done = done;
  end

  // Caller must be at a negedge; returns at the negedge after the done cycle.
  task automatic run_job(input string tag, input logic dec, input logic [3:0] r,
                         input logic [7:0] d, input logic [7:0] kk,
                         input logic [7:0] exp, input bit poke);
    int cyc;
    ops.delete();
    decrypt = dec; rounds = r; data_in = d; key = kk; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      cyc = i;
      if (i == 1) start = 1'b0;
      if (poke && i == 3) begin start = 1'b1; data_in = 8'hFF; key = 8'h11; end
      if (poke && i == 5) start = 1'b0;
      if (done) break;
      if (i == 60) cyc = 61;
    end
    chk({tag, "_lat"}, cyc, 32'(2 + 2 * int'(r)));
    chk({tag, "_data"}, {24'd0, data_out}, {24'd0, exp});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, {24'd0, data_out}, {24'd0, exp});
  endtask

  logic [7:0] exp_r2, dec_r2_in;
  int nd;

  initial begin
`ifdef KEY_ROTATE_EN
    exp_r2 = 8'h28; dec_r2_in = 8'h28;
`else
    exp_r2 = 8'hF4; dec_r2_in = 8'hF4;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_en",   {31'd0, alu_enable}, 32'd0);
    chk("rst_op",   {28'd0, alu_opcode}, 32'd0);
    chk("rst_ab",   {16'd0, alu_a, alu_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job("enc_r1", 1'b0, 4'd1, 8'h3C, 8'h5A, 8'hC0, 1'b0);
    chk("enc_r1_nops", ops.size(), 32'd3);
    chk("enc_r1_ops", {20'd0, ops[0], ops[1], ops[2]}, 32'h431);

    run_job("dec_r1", 1'b1, 4'd1, 8'hC0, 8'h5A, 8'h3C, 1'b0);
    chk("dec_r1_ops", {20'd0, ops[0], ops[1], ops[2]}, 32'h423);

    run_job("enc_wrap", 1'b0, 4'd1, 8'h7F, 8'hC0, 8'h7F, 1'b0);
    run_job("enc_r2", 1'b0, 4'd2, 8'h3C, 8'h5A, exp_r2, 1'b0);
    run_job("dec_r2", 1'b1, 4'd2, dec_r2_in, 8'h5A, 8'h3C, 1'b0);
    run_job("r0", 1'b0, 4'd0, 8'hA5, 8'h5A, 8'hA5, 1'b0);
    chk("r0_ops", {28'd0, ops[0]}, 32'h4);

    // Enc R=3 on 0x00 key 0x00 stays 0x00; a stray start carries data 0xFF.
    nd = n_done;
    run_job("poke", 1'b0, 4'd3, 8'h00, 8'h00, 8'h00, 1'b1);
    repeat (8) @(negedge clk);
    chk("poke_single_done", n_done - nd, 32'd1);
    chk("poke_data_hold", {24'd0, data_out}, 32'd0);

    // Back-to-back: start asserted in the cycle right after done.
    run_job("b2b", 1'b0, 4'd1, 8'h3C, 8'h5A, 8'hC0, 1'b0);

    nd = n_done;
    decrypt = 1'b0; rounds = 4'd2; data_in = 8'h3C; key = 8'h5A; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {24'd0, data_out}, 32'd0);
    chk("mid_rst_en", {31'd0, alu_enable}, 32'd0);
    repeat (8) @(negedge clk);
    chk("mid_rst_no_done", n_done - nd, 32'd0);

    run_job("after_rst", 1'b0, 4'd1, 8'h3C, 8'h5A, 8'hC0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
